// File: rtl/hept_seq_pkg.sv
// Shared types and defaults for the HEPT kernel sequencer.
// State encoding, counter width and watchdog limit defaults.
package hept_seq_pkg;

  localparam int CNT_W_DEF   = 32;
  localparam int TIMEOUT_DEF = 65535;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_TRANS = 3'd1,
    S_DIST  = 3'd2,
    S_NORM  = 3'd3,
    S_DONE  = 3'd4
  } seq_state_e;

  function automatic logic is_busy(seq_state_e s);
    return s inside {S_TRANS, S_DIST, S_NORM};
  endfunction

endpackage

// File: rtl/hept_stage_watchdog.sv
// Per-stage cycle watchdog: cleared on stage entry, counts while enabled.
// Expires in the TIMEOUT-th cycle of a stage; TIMEOUT of 0 disables it.
module hept_stage_watchdog
  import hept_seq_pkg::*;
#(
  parameter int CNT_W   = CNT_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && !(&cnt)) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign expired = (TIMEOUT != 0) && en && (cnt == LIMIT);

endmodule

// File: rtl/hept_kernel_sequencer.sv
// Top-level sequencer: transposes, distance/RBF, normalize, done.
// Every output is a flop fed from next-state logic.
module hept_kernel_sequencer
  import hept_seq_pkg::*;
#(
  parameter int CNT_W   = CNT_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic             ap_clk,
  input  logic             ap_rst_n,
  input  logic             ap_start,
  input  logic             ap_continue,
  output logic             ap_idle,
  output logic             ap_ready,
  output logic             ap_done,
  output logic             tq_start,
  output logic             tk_start,
  input  logic             tq_done,
  input  logic             tk_done,
  output logic             dist_start,
  input  logic             dist_done,
  output logic             norm_start,
  input  logic             norm_done,
  output logic [CNT_W-1:0] total_cycles,
  output logic             err_timeout,
  output logic [2:0]       state
);

  seq_state_e cur, nxt;
  logic tq_seen, tk_seen;
  logic tq_seen_nxt, tk_seen_nxt;
  logic accept, entry, expired;

  assign state = cur;

  always_comb begin
    nxt         = cur;
    tq_seen_nxt = tq_seen;
    tk_seen_nxt = tk_seen;
    accept      = 1'b0;
    unique case (cur)
      S_IDLE: begin
        if (ap_start) begin
          nxt    = S_TRANS;
          accept = 1'b1;
        end
      end
      S_TRANS: begin
        tq_seen_nxt = tq_seen | tq_done;
        tk_seen_nxt = tk_seen | tk_done;
        if (tq_seen_nxt && tk_seen_nxt) nxt = S_DIST;
      end
      S_DIST:  if (dist_done) nxt = S_NORM;
      S_NORM:  if (norm_done) nxt = S_DONE;
      S_DONE:  if (ap_continue) nxt = S_IDLE;
      default: nxt = S_IDLE;
    endcase
    if (expired) nxt = S_DONE;
    // latches only live inside TRANS; leaving it wipes them
    if (nxt != S_TRANS) begin
      tq_seen_nxt = 1'b0;
      tk_seen_nxt = 1'b0;
    end
  end

  assign entry = is_busy(nxt) && (nxt != cur);

  hept_stage_watchdog #(
    .CNT_W   (CNT_W),
    .TIMEOUT (TIMEOUT)
  ) u_wdog (
    .clk     (ap_clk),
    .rst_n   (ap_rst_n),
    .clr     (entry),
    .en      (is_busy(cur)),
    .expired (expired)
  );

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      cur          <= S_IDLE;
      tq_seen      <= 1'b0;
      tk_seen      <= 1'b0;
      ap_idle      <= 1'b1;
      ap_ready     <= 1'b0;
      ap_done      <= 1'b0;
      tq_start     <= 1'b0;
      tk_start     <= 1'b0;
      dist_start   <= 1'b0;
      norm_start   <= 1'b0;
      total_cycles <= '0;
      err_timeout  <= 1'b0;
    end else begin
      cur        <= nxt;
      tq_seen    <= tq_seen_nxt;
      tk_seen    <= tk_seen_nxt;
      ap_idle    <= (nxt == S_IDLE);
      ap_ready   <= (nxt == S_DONE) && (cur != S_DONE);
      ap_done    <= (nxt == S_DONE);
      tq_start   <= (nxt == S_TRANS) && !tq_seen_nxt;
      tk_start   <= (nxt == S_TRANS) && !tk_seen_nxt;
      dist_start <= (nxt == S_DIST);
      norm_start <= (nxt == S_NORM);
      if (accept) begin
        total_cycles <= '0;
      end else if (is_busy(cur) && !(&total_cycles)) begin
        total_cycles <= total_cycles + CNT_W'(1);
      end
      if (accept) begin
        err_timeout <= 1'b0;
      end else if (expired) begin
        err_timeout <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_hept_kernel_sequencer.sv
// Directed bench for hept_kernel_sequencer (TIMEOUT=8).
// Done pulses are placed in the k-th cycle of a stage, entry cycle = 1st.
module tb_hept_kernel_sequencer;

  logic        ap_clk = 1'b0;
  logic        ap_rst_n;
  logic        ap_start, ap_continue;
  logic        ap_idle, ap_ready, ap_done;
  logic        tq_start, tk_start, tq_done, tk_done;
  logic        dist_start, dist_done, norm_start, norm_done;
  logic [31:0] total_cycles;
  logic        err_timeout;
  logic [2:0]  state;

  int n_chk = 0;
  int n_err = 0;

  hept_kernel_sequencer #(
    .CNT_W   (32),
    .TIMEOUT (8)
  ) dut (
    .ap_clk       (ap_clk),
    .ap_rst_n     (ap_rst_n),
    .ap_start     (ap_start),
    .ap_continue  (ap_continue),
    .ap_idle      (ap_idle),
    .ap_ready     (ap_ready),
    .ap_done      (ap_done),
    .tq_start     (tq_start),
    .tk_start     (tk_start),
    .tq_done      (tq_done),
    .tk_done      (tk_done),
    .dist_start   (dist_start),
    .dist_done    (dist_done),
    .norm_start   (norm_start),
    .norm_done    (norm_done),
    .total_cycles (total_cycles),
    .err_timeout  (err_timeout),
    .state        (state)
  );

  always #5 ap_clk = ~ap_clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge ap_clk);
    #1;
  endtask

  task automatic tick_n(input int n);
    repeat (n) tick;
  endtask

  task automatic start_run;
    ap_start = 1'b1;
    tick;
    ap_start = 1'b0;
  endtask

  // From TRANS cycle 1: tq_done in cycle 3, tk_done in cycle 5.
  task automatic trans_phase(input bit stray);
    chk("trans_entry", state, 1);
    chk("tq_start_on", tq_start, 1);
    chk("tk_start_on", tk_start, 1);
    norm_done = stray;
    dist_done = stray;
    tick;
    norm_done = 1'b0;
    dist_done = 1'b0;
    chk("trans_hold", state, 1);
    chk("trans_total", total_cycles, 1);
    tick;
    tq_done = 1'b1;
    tick;
    tq_done = 1'b0;
    chk("tq_drop", tq_start, 0);
    chk("tk_hold", tk_start, 1);
    tick;
    tk_done = 1'b1;
    tick;
    tk_done = 1'b0;
    chk("dist_entry", state, 2);
    chk("dist_start_on", dist_start, 1);
    chk("tk_drop", tk_start, 0);
  endtask

  // From DIST cycle 1: dist_done in cycle 4.
  task automatic dist_phase;
    tick_n(3);
    dist_done = 1'b1;
    tick;
    dist_done = 1'b0;
    chk("norm_entry", state, 3);
    chk("norm_start_on", norm_start, 1);
    chk("dist_start_off", dist_start, 0);
  endtask

  // From NORM cycle 1: norm_done in cycle 2, then two DONE cycles.
  task automatic norm_phase;
    tick;
    norm_done = 1'b1;
    tick;
    norm_done = 1'b0;
    chk("done_state", state, 4);
    chk("done_flag", ap_done, 1);
    chk("ready_pulse", ap_ready, 1);
    chk("total_11", total_cycles, 11);
    chk("norm_start_off", norm_start, 0);
    chk("idle_off", ap_idle, 0);
    tick;
    chk("ready_one_cycle", ap_ready, 0);
    chk("done_held", ap_done, 1);
    chk("total_hold", total_cycles, 11);
  endtask

  task automatic continue_phase;
    ap_continue = 1'b1;
    tick;
    ap_continue = 1'b0;
    chk("back_idle", state, 0);
    chk("idle_on", ap_idle, 1);
    chk("done_clr", ap_done, 0);
  endtask

  initial begin
    ap_rst_n    = 1'b0;
    ap_start    = 1'b0;
    ap_continue = 1'b0;
    tq_done     = 1'b0;
    tk_done     = 1'b0;
    dist_done   = 1'b0;
    norm_done   = 1'b0;
    #12;
    chk("rst_state", state, 0);
    chk("rst_idle", ap_idle, 1);
    chk("rst_done", ap_done, 0);
    chk("rst_ready", ap_ready, 0);
    chk("rst_total", total_cycles, 0);
    chk("rst_err", err_timeout, 0);
    chk("rst_starts", {tq_start, tk_start, dist_start, norm_start}, 0);
    #5 ap_rst_n = 1'b1;
    tick;
    chk("post_rst_idle", state, 0);

    // nominal run
    start_run;
    trans_phase(1'b0);
    dist_phase;
    norm_phase;

    // ap_done held while ap_continue low, ap_start ignored
    ap_start = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick;
      chk("hold_done", ap_done, 1);
      chk("no_restart", state, 4);
    end
    ap_continue = 1'b1;
    tick;
    ap_continue = 1'b0;
    chk("start_ignored", state, 0);
    tick;
    ap_start = 1'b0;
    chk("restart", state, 1);

    // simultaneous transpose dones
    tq_done = 1'b1;
    tk_done = 1'b1;
    tick;
    tq_done = 1'b0;
    tk_done = 1'b0;
    chk("both_dist", state, 2);
    chk("both_dist_start", dist_start, 1);
    chk("both_tq_off", tq_start, 0);
    chk("both_tk_off", tk_start, 0);

    // watchdog: dist_done never comes
    tick_n(7);
    chk("wd_dist8", state, 2);
    chk("wd_dist8_start", dist_start, 1);
    chk("wd_no_err_yet", err_timeout, 0);
    tick;
    chk("wd_state", state, 4);
    chk("wd_dist_off", dist_start, 0);
    chk("wd_err", err_timeout, 1);
    chk("wd_done", ap_done, 1);
    chk("wd_total", total_cycles, 9);
    continue_phase;
    chk("wd_err_sticky", err_timeout, 1);
    start_run;
    chk("wd_err_clr", err_timeout, 0);
    chk("total_clr", total_cycles, 0);

    // stray dones in TRANS change nothing
    trans_phase(1'b1);
    dist_phase;
    norm_phase;
    continue_phase;

    // asynchronous reset mid-NORM, then a clean run
    start_run;
    trans_phase(1'b0);
    dist_phase;
    #2 ap_rst_n = 1'b0;
    #1;
    chk("arst_state", state, 0);
    chk("arst_idle", ap_idle, 1);
    chk("arst_norm", norm_start, 0);
    chk("arst_total", total_cycles, 0);
    chk("arst_flags", {ap_done, ap_ready, err_timeout}, 0);
    chk("arst_starts", {tq_start, tk_start, dist_start}, 0);
    #2 ap_rst_n = 1'b1;
    tick;
    chk("arst_rel_idle", state, 0);
    start_run;
    trans_phase(1'b0);
    dist_phase;
    norm_phase;
    continue_phase;

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/hept_kernel_sequencer.md
HEPT_KERNEL_SEQUENCER -- requirements
Module: hept_kernel_sequencer

Interface
REQ-001 Parameter CNT_W, default 32: width of the cycle counter and the watchdog counter.
REQ-002 Parameter TIMEOUT, default 65535: maximum number of cycles per stage before a timeout; a value of 0 disables the watchdog.
REQ-003 Port ap_clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 Port ap_rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-005 Port ap_start, input, 1 bit: kernel start request.
REQ-006 Port ap_continue, input, 1 bit: acknowledge of ap_done.
REQ-007 Ports ap_idle, ap_ready and ap_done, output, 1 bit each: top-level block handshake.
REQ-008 Ports tq_start and tk_start, output, 1 bit each: starts for the Q transpose and the K transpose.
REQ-009 Ports tq_done and tk_done, input, 1 bit each: one-cycle done pulses from the two transposes.
REQ-010 Ports dist_start (output) and dist_done (input), 1 bit each: pairwise-distance/RBF stage.
REQ-011 Ports norm_start (output) and norm_done (input), 1 bit each: mask-and-normalize stage.
REQ-012 Port total_cycles, output, CNT_W bits: cycle count of the last run.
REQ-013 Port err_timeout, output, 1 bit: sticky watchdog error.
REQ-014 Port state, output, 3 bits: current FSM state encoding.

Function
REQ-015 The FSM SHALL have the states IDLE, TRANS, DIST, NORM and DONE.
REQ-016 IDLE: ap_idle=1 and all stage starts are 0; ap_start=1 sampled in cycle N SHALL give TRANS in N+1.
REQ-017 TRANS: tq_start and tk_start SHALL both be held at 1, and each SHALL drop the cycle after its own done is seen.
REQ-018 tq_done and tk_done SHALL be latched independently, and the FSM SHALL go to DIST the cycle after both latches are set; a same-cycle arrival of both dones counts as both.
REQ-019 DIST: dist_start SHALL be held at 1 until dist_done; dist_done in cycle M SHALL give NORM with norm_start=1 in M+1.
REQ-020 NORM: norm_start SHALL be held at 1 until norm_done; norm_done in cycle M SHALL give DONE in M+1.
REQ-021 ap_ready SHALL pulse for exactly one cycle, in the first DONE cycle.
REQ-022 DONE: ap_done=1 SHALL be held until ap_continue=1 is sampled, then the FSM goes to IDLE; an ap_start in that same cycle is ignored.
REQ-023 A done from a stage that is not currently active (stray done) SHALL be ignored; it SHALL NOT alter the latches or the state.
REQ-024 total_cycles SHALL clear on entry to TRANS, increment every cycle in TRANS, DIST and NORM, and hold its value in DONE and IDLE.
REQ-025 Watchdog: a per-stage counter SHALL clear on each stage entry; when it reaches TIMEOUT (TIMEOUT≠0), all starts deassert, err_timeout is set, and the FSM goes to DONE.
REQ-026 err_timeout SHALL clear only when the next ap_start is accepted in IDLE.
REQ-027 All outputs SHALL be registered; none is combinational from any input.
REQ-028 The counters SHALL saturate at all-ones and never wrap.

Reset
REQ-029 Asserting ap_rst_n=0 at any time, including mid-run, SHALL asynchronously force state=IDLE, ap_idle=1, all other outputs 0, total_cycles=0 and both done latches cleared.
REQ-030 Reset SHALL be released synchronously to ap_clk, and the first active edge after release SHALL evaluate IDLE.

Structure
REQ-031 Package hept_seq_pkg SHALL hold the state enum and the default constants for CNT_W and TIMEOUT.
REQ-032 A single sub-module, hept_stage_watchdog, SHALL hold the counter, clear, enable and expiry logic, and it SHALL be instantiated once.

Verification
REQ-033 Nominal run: tq_done at +3 and tk_done at +5 after TRANS entry, dist_done at +4, norm_done at +2 -> ap_done with total_cycles=11 and ap_ready high for exactly one cycle.
REQ-034 tq_done and tk_done asserted in the same cycle -> DIST entered the next cycle and dist_start=1.
REQ-035 With ap_continue held 0 for 10 cycles and ap_start=1 throughout -> ap_done stays 1, no restart, and the next run begins only after ap_continue.
REQ-036 With TIMEOUT=8 and dist_done never asserted -> dist_start drops after 8 DIST cycles, err_timeout=1 and state=DONE; the next accepted ap_start clears err_timeout.
REQ-037 ap_rst_n pulsed low mid-NORM -> all outputs reach reset values asynchronously and the following run completes normally.
REQ-038 A stray norm_done while in TRANS -> it is ignored and the sequence and total_cycles are unchanged.
